pipe_hazard_ctrl: RTL and testbench

Central hazard and pipeline-control unit for the 5-stage RISC-V pipeline. It reads the contents of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives the write-enable and flush controls of those registers and of the PC. It also drives the EX-stage forwarding selects and sequences the halt drain. It owns saturating stall/flush event counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 92 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, forwarding selects, halt drain sequencing and stall/flush event counters
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_instr,
  input  logic             if_id_halt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic             ex_mem_regwrite,
  input  logic [4:0]       ex_mem_rd,
  input  logic             mem_wb_regwrite,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_halt,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             halted,
  output logic             halt_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
  logic [1:0]    state;
  logic [DW-1:0] drain_cnt;
  logic [3:0]    ctrl;
  logic          luse;
  logic          unused_instr;
  assign unused_instr = ^{if_id_instr[31:25], if_id_instr[14:0]};
  assign luse = id_ex_memread && id_ex_rd != 5'd0 &&
                (id_ex_rd == if_id_instr[19:15] || id_ex_rd == if_id_instr[24:20]);
  assign forward_a = !reset ? 2'b00 :
                     (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs1) ? 2'b10 :
                     (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs1) ? 2'b01 : 2'b00;
  assign forward_b = !reset ? 2'b00 :
                     (ex_mem_regwrite && ex_mem_rd != 5'd0 && ex_mem_rd == id_ex_rs2) ? 2'b10 :
                     (mem_wb_regwrite && mem_wb_rd != 5'd0 && mem_wb_rd == id_ex_rs2) ? 2'b01 : 2'b00;
  // ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush}
  always_comb begin
    ctrl = !reset           ? 4'b0011 :
           state == DRAIN   ? 4'b0110 :
           state == HALTED  ? 4'b0011 :
           ex_branch_taken  ? 4'b1111 :
           luse             ? 4'b0001 :
           if_id_halt       ? 4'b0110 : 4'b1100;
  end
  assign {pc_write, if_id_write, if_id_flush, id_ex_flush} = ctrl;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      halt_err    <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (state == RUN) begin
      if (ex_branch_taken) begin
        if (~&flush_count) flush_count <= flush_count + CNT_W'(1);
      end else if (luse) begin
        if (~&stall_count) stall_count <= stall_count + CNT_W'(1);
      end else if (if_id_halt) begin
        state     <= DRAIN;
        drain_cnt <= '0;
      end
    end else if (state == DRAIN) begin
      if (mem_wb_halt) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else if (drain_cnt == DRAIN_LAST) begin
        state    <= HALTED;
        halted   <= 1'b1;
        halt_err <= 1'b1;
      end else begin
        drain_cnt <= drain_cnt + DW'(1);
      end
    end else if (state != HALTED) begin
      state <= RUN;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, directed corner sequences and randomized run against a rule-level model
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int DM = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] if_id_instr = '0;
  logic if_id_halt = 1'b0, id_ex_memread = 1'b0, ex_mem_regwrite = 1'b0, mem_wb_regwrite = 1'b0;
  logic mem_wb_halt = 1'b0, ex_branch_taken = 1'b0;
  logic [4:0] id_ex_rd = '0, id_ex_rs1 = '0, id_ex_rs2 = '0, ex_mem_rd = '0, mem_wb_rd = '0;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, halted, halt_err;
  logic [1:0] forward_a, forward_b;
  logic [CW-1:0] stall_count, flush_count;
  pipe_hazard_ctrl #(.CNT_W(CW), .DRAIN_MAX(DM)) dut (
    .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .if_id_halt(if_id_halt),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_rd(mem_wb_rd), .mem_wb_halt(mem_wb_halt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .forward_a(forward_a), .forward_b(forward_b), .halted(halted), .halt_err(halt_err),
    .stall_count(stall_count), .flush_count(flush_count));
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  int mode = 0, dcnt = 0, m_stall = 0, m_flush = 0;
  bit m_halted = 1'b0, m_err = 1'b0;
  logic [3:0] s_ctrl;
  logic [1:0] s_fa, s_fb;
  typedef struct {
    logic mr; logic [4:0] xrd, i1, i2;
    logic ew; logic [4:0] erd; logic ww; logic [4:0] wrd, r1, r2;
    logic [1:0] fa, fb; logic stall;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic logic m_luse();
    return id_ex_memread && id_ex_rd != 0 &&
           (id_ex_rd == if_id_instr[19:15] || id_ex_rd == if_id_instr[24:20]);
  endfunction
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!reset) return 2'b00;
    if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic [3:0] m_ctrl();
    if (!reset || mode == 2) return 4'b0011;
    if (mode == 1) return 4'b0110;
    if (ex_branch_taken) return 4'b1111;
    if (m_luse()) return 4'b0001;
    if (if_id_halt) return 4'b0110;
    return 4'b1100;
  endfunction
  task automatic model_edge();
    int sat = (1 << CW) - 1;
    if (!reset) begin
      mode = 0; dcnt = 0; m_halted = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else if (mode == 0) begin
      if (ex_branch_taken) m_flush = (m_flush < sat) ? m_flush + 1 : sat;
      else if (m_luse()) m_stall = (m_stall < sat) ? m_stall + 1 : sat;
      else if (if_id_halt) begin mode = 1; dcnt = 0; end
    end else if (mode == 1) begin
      if (mem_wb_halt) begin mode = 2; m_halted = 1; end
      else if (dcnt == DM - 1) begin mode = 2; m_halted = 1; m_err = 1; end
      else dcnt++;
    end
  endtask
  // one cycle: sample mid-cycle against the model, then advance the model across the edge
  task automatic cyc();
    #4;
    s_ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush};
    s_fa = forward_a;
    s_fb = forward_b;
    chk("ctrl", 32'(s_ctrl), 32'(m_ctrl()));
    chk("fwd", 32'({s_fa, s_fb}), 32'({m_fwd(id_ex_rs1), m_fwd(id_ex_rs2)}));
    chk("regs", 32'({halted, halt_err, stall_count, flush_count}),
        32'({m_halted, m_err, CW'(m_stall), CW'(m_flush)}));
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic idle();
    reset = 1; if_id_instr = '0; if_id_halt = 0; id_ex_memread = 0; id_ex_rd = 0;
    id_ex_rs1 = 0; id_ex_rs2 = 0; ex_mem_regwrite = 0; ex_mem_rd = 0; mem_wb_regwrite = 0;
    mem_wb_rd = 0; mem_wb_halt = 0; ex_branch_taken = 0;
  endtask
  task automatic do_reset();
    idle(); reset = 0; cyc(); reset = 1;
  endtask
  task automatic set_luse();
    id_ex_memread = 1; id_ex_rd = 5'd7; if_id_instr = {7'd0, 5'd7, 5'd2, 15'd0};
  endtask
  initial begin
    tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 2'b10, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 2'b01, 2'b00, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 5'd4, 5'd4, 5'd3, 2'b01, 2'b10, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 5'd9, 5'd1, 5'd9, 2'b00, 2'b01, 1'b0};
    tbl[5] = '{1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1};
    tbl[6] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
    tbl[7] = '{1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
    tbl[8] = '{1'b1, 5'd12, 5'd12, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1};
    tbl[9] = '{1'b1, 5'd12, 5'd3, 5'd4, 1'b1, 5'd12, 1'b0, 5'd0, 5'd12, 5'd12, 2'b10, 2'b10, 1'b0};
    @(posedge clk); #1;
    do_reset();
    chk("rst_ctrl", 32'(s_ctrl), 32'h3);
    chk("rst_regs", 32'({halted, halt_err, stall_count, flush_count}), 32'h0);
    for (int i = 0; i < 10; i++) begin
      idle();
      id_ex_memread = tbl[i].mr; id_ex_rd = tbl[i].xrd;
      if_id_instr = {7'd0, tbl[i].i2, tbl[i].i1, 15'd0};
      ex_mem_regwrite = tbl[i].ew; ex_mem_rd = tbl[i].erd;
      mem_wb_regwrite = tbl[i].ww; mem_wb_rd = tbl[i].wrd;
      id_ex_rs1 = tbl[i].r1; id_ex_rs2 = tbl[i].r2;
      cyc();
      chk("tbl_fa", 32'(s_fa), 32'(tbl[i].fa));
      chk("tbl_fb", 32'(s_fb), 32'(tbl[i].fb));
      chk("tbl_pcw", 32'(s_ctrl[3]), 32'(!tbl[i].stall));
    end
    do_reset();
    set_luse();
    for (int i = 0; i < 3; i++) begin cyc(); chk("lu_ctrl", 32'(s_ctrl), 32'h1); end
    chk("lu_cnt", 32'(stall_count), 32'd3);
    ex_branch_taken = 1; cyc();
    chk("br_ctrl", 32'(s_ctrl), 32'hF);
    chk("br_cnt", 32'({stall_count, flush_count}), 32'({4'd3, 4'd1}));
    do_reset();
    idle(); if_id_halt = 1; cyc();
    chk("hd_n", 32'(s_ctrl), 32'h6);
    idle(); cyc();
    chk("hd_n1", 32'({s_ctrl, halted}), 32'({4'h6, 1'b0}));
    ex_branch_taken = 1; cyc();
    chk("hd_br_ign", 32'({s_ctrl, flush_count}), 32'({4'h6, 4'd0}));
    idle(); mem_wb_halt = 1; cyc();
    chk("hd_halted", 32'({halted, halt_err}), 32'b10);
    idle(); ex_branch_taken = 1; cyc();
    chk("hd_frozen", 32'({s_ctrl, flush_count, halted}), 32'({4'h3, 4'd0, 1'b1}));
    do_reset();
    idle(); if_id_halt = 1; cyc();
    idle(); cyc(); cyc();
    chk("to_early", 32'(halted), 32'd0);
    cyc();
    chk("to_done", 32'({halted, halt_err}), 32'b11);
    do_reset();
    set_luse(); cyc(); cyc();
    idle(); if_id_halt = 1; cyc();
    idle(); cyc();
    reset = 0; cyc(); reset = 1;
    chk("rd_regs", 32'({halted, halt_err, stall_count, flush_count}), 32'h0);
    cyc();
    chk("rd_run", 32'(s_ctrl), 32'hC);
    set_luse(); if_id_halt = 1; cyc();
    chk("lh_stall", 32'(s_ctrl), 32'h1);
    id_ex_memread = 0; cyc();
    chk("lh_halt", 32'(s_ctrl), 32'h6);
    if_id_halt = 0; cyc();
    chk("lh_drain", 32'(s_ctrl), 32'h6);
    do_reset();
    idle(); if_id_halt = 1; ex_branch_taken = 1; cyc();
    chk("bh_flush", 32'(s_ctrl), 32'hF);
    idle(); cyc();
    chk("bh_run", 32'(s_ctrl), 32'hC);
    do_reset();
    set_luse();
    for (int i = 0; i < 20; i++) cyc();
    chk("sat", 32'(stall_count), 32'd15);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 64) != 0;
      if_id_instr = $urandom;
      if_id_instr[19:15] = 5'($urandom % 4);
      if_id_instr[24:20] = 5'($urandom % 4);
      if_id_halt = ($urandom % 10) == 0;
      id_ex_memread = $urandom % 2;
      id_ex_rd = 5'($urandom % 4);
      id_ex_rs1 = 5'($urandom % 4);
      id_ex_rs2 = 5'($urandom % 4);
      ex_mem_regwrite = $urandom % 2;
      ex_mem_rd = 5'($urandom % 4);
      mem_wb_regwrite = $urandom % 2;
      mem_wb_rd = 5'($urandom % 4);
      mem_wb_halt = ($urandom % 4) == 0;
      ex_branch_taken = ($urandom % 5) == 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
